sr_ff_monitor: RTL and testbench
================================

// Module: sr_ff_monitor
// PURPOSE
//   Synthesizable observer for a clocked SR flip-flop. It sits beside the flop on the same set/reset/q/q_n nets and
//   samples them every rising clk edge. It keeps its own model of the stored bit, compares the flop outputs against
//   that model, and flags illegal S=R=1 commands. It keeps error/check counts and a sticky fail flag that bench or
//   silicon debug logic reads.
// PARAMETERS
//   CNT_W        8   width of err_cnt and chk_cnt (both saturate at all-ones)
//   COMPL_CHECK  1   1: also check q_n == ~q; 0: ignore q_n, err_compl tied 0
// PORTS
//   clk           in   1      clock; same clock that drives the observed flop, rising edge
//   rst_n         in   1      asynchronous, active-low reset
//   clr           in   1      sync clear of err_cnt, chk_cnt, fail (model state untouched)
//   set           in   1      observed set command to the flop
//   reset         in   1      observed reset command to the flop (data input, not a monitor reset)
//   q             in   1      observed flop output
//   q_n           in   1      observed complementary flop output
//   state         out  2      model state: 00 UNKNOWN, 01 KNOWN0, 10 KNOWN1, 11 ILLEGAL
//   err_mismatch  out  1      1-cycle pulse: q differed from model
//   err_compl     out  1      1-cycle pulse: q_n != ~q
//   err_illegal   out  1      1-cycle pulse: set=reset=1 sampled
//   fail          out  1      sticky OR of all error pulses
//   err_cnt       out  CNT_W  total error events, saturating
//   chk_cnt       out  CNT_W  comparisons performed, saturating
// BEHAVIOUR
//   - rst_n low, asynchronous: state=UNKNOWN, all pulses 0, fail=0, err_cnt=0, chk_cnt=0, immediately and held.
//   - Applies mid-operation too. The first edge after release is a normal edge.
//   - All outputs are registered. Every edge evaluates compare, then next-state, from the pre-edge state.
//   - Compare, at edge k, only when state is KNOWN0 or KNOWN1:
//     - expected q = 0 (KNOWN0) or 1 (KNOWN1).
//     - err_mismatch = (q != expected).
//     - err_compl = COMPL_CHECK && (q_n == q).
//     - chk_cnt += 1.
//     - In UNKNOWN/ILLEGAL: no compare, no chk_cnt increment, err_mismatch = err_compl = 0.
//   - Next state, from {set,reset} sampled at edge k:
//     - 10 -> KNOWN1
//     - 01 -> KNOWN0
//     - 00 -> hold
//     - 11 -> ILLEGAL, and err_illegal = 1
//   - Latency: a command sampled at edge k is checked against q at edge k+1, since the flop updates at edge k.
//   - Mismatch at edge k+1 drives err_mismatch high from k+1 to k+2.
//   - err_illegal is high for the cycle after the edge that sampled 11.
//   - 11 held for N edges: err_illegal high N consecutive cycles; the state stays ILLEGAL.
//   - Leaving ILLEGAL/UNKNOWN needs 10 or 01; 00 does not leave them.
//   - err_cnt += (err_mismatch + err_compl + err_illegal) produced at this edge, i.e. 0..3 per edge.
//   - Saturates at 2^CNT_W-1 with no wrap. chk_cnt also saturates with no wrap.
//   - fail sets on any error pulse and is cleared only by clr or rst_n.
//   - clr at an edge: counters and fail restart from 0.
//     - That same edge's contributions still apply, e.g. clr plus a mismatch gives err_cnt=1, fail=1.
//   - clr does not alter state or the pulses.
// TESTING
//   T1 reset: rst_n=0 mid-run with err_cnt=5, fail=1 -> all outputs 0, state=00 at once, no clock needed.
//   T2 set/reset sequence: flop SR=00,01,10,00 for 5 edges each -> state 01 then 10.
//      No errors; chk_cnt=14 (00 edges in UNKNOWN not counted).
//   T3 illegal: SR=11 for 5 edges -> err_illegal high 5 cycles, state=11, err_cnt=5, fail=1.
//      Then SR=00 for 3 edges -> state stays 11, chk_cnt unchanged.
//   T4 fault inject: after SR=10, force q=0, q_n=0 for 1 edge -> err_mismatch=1 and err_compl=1 same cycle, err_cnt +=2.
//      Repeat with COMPL_CHECK=0 -> only err_mismatch, err_cnt +=1.
//   T5 saturation/clear: CNT_W=3, inject 10 mismatches -> err_cnt=7 holds.
//      clr coincident with a mismatch -> err_cnt=1, fail=1; clr alone next -> err_cnt=0, fail=0.

Source files
------------

// File: rtl/sr_ff_monitor.sv
// Observer for a clocked SR flip-flop: tracks the expected stored bit, checks q/q_n against it,
// flags illegal set=reset=1 commands and keeps saturating error/check counters plus a sticky fail flag.
module sr_ff_monitor #(
    parameter int CNT_W       = 8,
    parameter bit COMPL_CHECK = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             set,
    input  logic             reset,
    input  logic             q,
    input  logic             q_n,
    output logic [1:0]       state,
    output logic             err_mismatch,
    output logic             err_compl,
    output logic             err_illegal,
    output logic             fail,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] chk_cnt
);

    localparam logic [1:0] ST_UNKNOWN = 2'b00;
    localparam logic [1:0] ST_KNOWN0  = 2'b01;
    localparam logic [1:0] ST_KNOWN1  = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W+1:0] CNT_MAX_EXT = {2'b00, {CNT_W{1'b1}}};

    logic [1:0]       state_q, state_d;
    logic             mismatch_q, mismatch_d;
    logic             compl_q, compl_d;
    logic             illegal_q, illegal_d;
    logic             fail_q, fail_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;

    logic             known;
    logic [1:0]       err_incr;
    logic [CNT_W-1:0] err_base, chk_base;
    logic [CNT_W+1:0] err_sum;

    always_comb begin
        known      = (state_q == ST_KNOWN0) || (state_q == ST_KNOWN1);
        mismatch_d = known && (q != (state_q == ST_KNOWN1));
        compl_d    = known && COMPL_CHECK && (q_n == q);
        illegal_d  = set && reset;

        state_d = state_q;
        case ({set, reset})
            2'b10:   state_d = ST_KNOWN1;
            2'b01:   state_d = ST_KNOWN0;
            2'b11:   state_d = ST_ILLEGAL;
            default: state_d = state_q;
        endcase

        // clr restarts the counters from zero but this edge's own events still count
        err_base = clr ? '0 : err_cnt_q;
        chk_base = clr ? '0 : chk_cnt_q;

        err_incr  = {1'b0, mismatch_d} + {1'b0, compl_d} + {1'b0, illegal_d};
        err_sum   = {2'b00, err_base} + {{CNT_W{1'b0}}, err_incr};
        err_cnt_d = (err_sum > CNT_MAX_EXT) ? CNT_MAX : err_sum[CNT_W-1:0];

        chk_cnt_d = chk_base;
        if (known && (chk_base != CNT_MAX)) begin
            chk_cnt_d = chk_base + CNT_W'(1);
        end

        fail_d = (clr ? 1'b0 : fail_q) | mismatch_d | compl_d | illegal_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_UNKNOWN;
            mismatch_q <= 1'b0;
            compl_q    <= 1'b0;
            illegal_q  <= 1'b0;
            fail_q     <= 1'b0;
            err_cnt_q  <= '0;
            chk_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            mismatch_q <= mismatch_d;
            compl_q    <= compl_d;
            illegal_q  <= illegal_d;
            fail_q     <= fail_d;
            err_cnt_q  <= err_cnt_d;
            chk_cnt_q  <= chk_cnt_d;
        end
    end

    assign state        = state_q;
    assign err_mismatch = mismatch_q;
    assign err_compl    = compl_q;
    assign err_illegal  = illegal_q;
    assign fail         = fail_q;
    assign err_cnt      = err_cnt_q;
    assign chk_cnt      = chk_cnt_q;

endmodule

// File: tb/tb_sr_ff_monitor.sv
// Self-checking bench for sr_ff_monitor: three instances (default, no complement check, 3-bit counters)
// share one stimulus stream and are compared against a behavioural model of the observed flop and monitor.
module tb_sr_ff_monitor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic set = 1'b0;
    logic reset = 1'b0;
    logic q = 1'b0;
    logic q_n = 1'b1;

    logic [1:0] state0, state1, state2;
    logic       mis0, mis1, mis2;
    logic       cmp0, cmp1, cmp2;
    logic       ill0, ill1, ill2;
    logic       fail0, fail1, fail2;
    logic [7:0] err0, err1, chk0, chk1;
    logic [2:0] err2, chk2;

    int checkCount = 0;
    int errorCount = 0;

    // Observed flop value and per-instance reference state; mVal: -1 unknown, -2 illegal, else stored bit
    logic flopQ = 1'b0;
    int   mVal[3];
    int   mErr[3];
    int   mChk[3];
    bit   mFail[3];
    bit   mMis[3];
    bit   mCmp[3];
    bit   mIll[3];
    int   cntW[3]  = '{8, 8, 3};
    bit   compl[3] = '{1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    sr_ff_monitor #(.CNT_W(8), .COMPL_CHECK(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .set(set), .reset(reset), .q(q), .q_n(q_n),
        .state(state0), .err_mismatch(mis0), .err_compl(cmp0), .err_illegal(ill0),
        .fail(fail0), .err_cnt(err0), .chk_cnt(chk0)
    );

    sr_ff_monitor #(.CNT_W(8), .COMPL_CHECK(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .set(set), .reset(reset), .q(q), .q_n(q_n),
        .state(state1), .err_mismatch(mis1), .err_compl(cmp1), .err_illegal(ill1),
        .fail(fail1), .err_cnt(err1), .chk_cnt(chk1)
    );

    sr_ff_monitor #(.CNT_W(3), .COMPL_CHECK(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .set(set), .reset(reset), .q(q), .q_n(q_n),
        .state(state2), .err_mismatch(mis2), .err_compl(cmp2), .err_illegal(ill2),
        .fail(fail2), .err_cnt(err2), .chk_cnt(chk2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] expState(input int i);
        if (mVal[i] == -1) return 32'd0;
        if (mVal[i] == -2) return 32'd3;
        return (mVal[i] == 1) ? 32'd2 : 32'd1;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            mVal[i] = -1; mErr[i] = 0; mChk[i] = 0;
            mFail[i] = 1'b0; mMis[i] = 1'b0; mCmp[i] = 1'b0; mIll[i] = 1'b0;
        end
    endtask

    // One rising edge as seen by instance i, using the inputs present just before the edge
    task automatic modelStep(input int i);
        int cap;
        bit known;
        cap      = (1 << cntW[i]) - 1;
        known    = (mVal[i] >= 0);
        mMis[i]  = known && (int'(q) != mVal[i]);
        mCmp[i]  = known && compl[i] && (q_n == q);
        mIll[i]  = set && reset;
        if (clr) begin
            mErr[i] = 0; mChk[i] = 0; mFail[i] = 1'b0;
        end
        mErr[i]  = mErr[i] + int'(mMis[i]) + int'(mCmp[i]) + int'(mIll[i]);
        if (mErr[i] > cap) mErr[i] = cap;
        if (known && mChk[i] < cap) mChk[i] = mChk[i] + 1;
        mFail[i] = mFail[i] | mMis[i] | mCmp[i] | mIll[i];
        if (set && !reset) mVal[i] = 1;
        else if (!set && reset) mVal[i] = 0;
        else if (set && reset) mVal[i] = -2;
    endtask

    task automatic checkInst(input int i, input string name, input logic [1:0] st, input logic mis,
                             input logic cmp, input logic ill, input logic fl,
                             input logic [7:0] ec, input logic [7:0] cc);
        checkOutput({name, "_state"}, 32'(st), expState(i));
        checkOutput({name, "_mismatch"}, 32'(mis), 32'(mMis[i]));
        checkOutput({name, "_compl"}, 32'(cmp), 32'(mCmp[i]));
        checkOutput({name, "_illegal"}, 32'(ill), 32'(mIll[i]));
        checkOutput({name, "_fail"}, 32'(fl), 32'(mFail[i]));
        checkOutput({name, "_err_cnt"}, 32'(ec), 32'(mErr[i]));
        checkOutput({name, "_chk_cnt"}, 32'(cc), 32'(mChk[i]));
    endtask

    task automatic checkAll();
        checkInst(0, "u0", state0, mis0, cmp0, ill0, fail0, err0, chk0);
        checkInst(1, "u1", state1, mis1, cmp1, ill1, fail1, err1, chk1);
        checkInst(2, "u2", state2, mis2, cmp2, ill2, fail2, {5'b0, err2}, {5'b0, chk2});
    endtask

    // Drive one cycle of commands; a fault inverts q and forces q_n to the given value
    task automatic applyStimulus(input logic s, input logic r, input logic c,
                                 input bit fault, input logic faultQn);
        set   = s;
        reset = r;
        clr   = c;
        q     = fault ? ~flopQ : flopQ;
        q_n   = fault ? faultQn : ~flopQ;
        @(posedge clk);
        for (int i = 0; i < 3; i++) modelStep(i);
        if (s && !r) flopQ = 1'b1;
        else if (!s && r) flopQ = 1'b0;
        #1;
        checkAll();
    endtask

    task automatic asyncReset();
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        modelReset();
        #12;
        checkAll();
        @(negedge clk);
        rst_n = 1'b1;

        // set/reset sequence from power-up
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("T2_state_known0", 32'(state0), 32'd1);
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("T2_state_known1", 32'(state0), 32'd2);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("T2_chk_cnt", 32'(chk0), 32'd14);
        checkOutput("T2_err_cnt", 32'(err0), 32'd0);

        // illegal command held, then 00 does not leave ILLEGAL
        repeat (5) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("T3_illegal_pulse", 32'(ill0), 32'd1);
        end
        checkOutput("T3_err_cnt", 32'(err0), 32'd5);
        checkOutput("T3_fail", 32'(fail0), 32'd1);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("T3_state_stuck", 32'(state0), 32'd3);
        checkOutput("T3_chk_cnt", 32'(chk0), 32'd15);

        // asynchronous reset mid-run, no clock edge involved
        asyncReset();
        checkOutput("T1_err_cnt", 32'(err0), 32'd0);
        checkOutput("T1_fail", 32'(fail0), 32'd0);
        checkOutput("T1_state", 32'(state0), 32'd0);

        // fault injection: q=0 and q_n=0 while KNOWN1
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("T4_mismatch", 32'(mis0), 32'd1);
        checkOutput("T4_compl", 32'(cmp0), 32'd1);
        checkOutput("T4_err_cnt", 32'(err0), 32'd2);
        checkOutput("T4_nc_compl", 32'(cmp1), 32'd0);
        checkOutput("T4_nc_err_cnt", 32'(err1), 32'd1);

        // saturation and clear on the 3-bit instance
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("T5_sat_err_cnt", 32'(err2), 32'd7);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("T5_clr_mis_err_cnt", 32'(err2), 32'd1);
        checkOutput("T5_clr_mis_fail", 32'(fail2), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("T5_clr_err_cnt", 32'(err2), 32'd0);
        checkOutput("T5_clr_fail", 32'(fail2), 32'd0);
        checkOutput("T5_clr_chk_cnt", 32'(chk2), 32'd1);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            int pick;
            logic s, r;
            pick = int'($urandom_range(0, 99));
            if (pick < 45) begin s = 1'b0; r = 1'b0; end
            else if (pick < 65) begin s = 1'b1; r = 1'b0; end
            else if (pick < 85) begin s = 1'b0; r = 1'b1; end
            else begin s = 1'b1; r = 1'b1; end
            if ($urandom_range(0, 99) < 2) asyncReset();
            applyStimulus(s, r, ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 99) < 12) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
